// File: rtl/quant_pkg.sv
// quant_pkg: shared constants and types for the streaming JPEG quantizer.
//   BLK_LEN           : coefficients per 8x8 block
//   LUMA_Q / CHROMA_Q : standard JPEG quantization tables, raster order
//   recip()           : R = ceil(2^s / q)
//   recip_table()     : 64-entry reciprocal table for a given input width
//   side_t            : per-stage sideband (valid, sign, sof, eob)
// The QUANT_ROUND_EN build uses the same tables; only the numerator changes.
package quant_pkg;

    localparam int unsigned BLK_LEN = 64;

    localparam logic [6:0] LUMA_Q [BLK_LEN] = '{
        7'd16, 7'd11, 7'd10, 7'd16, 7'd24,  7'd40,  7'd51,  7'd61,
        7'd12, 7'd12, 7'd14, 7'd19, 7'd26,  7'd58,  7'd60,  7'd55,
        7'd14, 7'd13, 7'd16, 7'd24, 7'd40,  7'd57,  7'd69,  7'd56,
        7'd14, 7'd17, 7'd22, 7'd29, 7'd51,  7'd87,  7'd80,  7'd62,
        7'd18, 7'd22, 7'd37, 7'd56, 7'd68,  7'd109, 7'd103, 7'd77,
        7'd24, 7'd35, 7'd55, 7'd64, 7'd81,  7'd104, 7'd113, 7'd92,
        7'd49, 7'd64, 7'd78, 7'd87, 7'd103, 7'd121, 7'd120, 7'd101,
        7'd72, 7'd92, 7'd95, 7'd98, 7'd112, 7'd100, 7'd103, 7'd99
    };

    localparam logic [6:0] CHROMA_Q [BLK_LEN] = '{
        7'd17, 7'd18, 7'd24, 7'd47, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd18, 7'd21, 7'd26, 7'd66, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd24, 7'd26, 7'd56, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd47, 7'd66, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99
    };

    typedef logic [BLK_LEN-1:0][31:0] recip_tab_t;

    typedef struct packed {
        logic valid;
        logic sign;
        logic sof;
        logic eob;
    } side_t;

    // Only evaluated at elaboration; no divider reaches the netlist.
    function automatic logic [31:0] recip(input int unsigned s, input logic [6:0] q);
        logic [63:0] num;
        num = (64'd1 << s) + 64'(q) - 64'd1;
        return 32'(num / 64'(q));
    endfunction

    function automatic recip_tab_t recip_table(input int unsigned in_w, input logic chroma);
        recip_tab_t t;
        for (int i = 0; i < BLK_LEN; i++) begin
            t[i] = recip(in_w + 8, chroma ? CHROMA_Q[i] : LUMA_Q[i]);
        end
        return t;
    endfunction

endpackage

// File: rtl/quant_stream_if.sv
// quant_stream_if: coefficient stream in, quantized stream out, sync error flag.
//   master : the side feeding coefficients and accepting results
//   slave  : the quantizer
interface quant_stream_if #(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned OUT_W = 12
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_coeff;
    logic                    in_sof;
    logic                    in_chroma;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_coeff;
    logic                    out_sof;
    logic                    out_eob;
    logic                    err_sync;

    modport master (
        output in_valid, in_coeff, in_sof, in_chroma, out_ready,
        input  in_ready, out_valid, out_coeff, out_sof, out_eob, err_sync
    );

    modport slave (
        input  in_valid, in_coeff, in_sof, in_chroma, out_ready,
        output in_ready, out_valid, out_coeff, out_sof, out_eob, err_sync
    );
endinterface

// File: rtl/quant_recip_lut.sv
// quant_recip_lut: combinational (idx, chroma) -> (Q, R) lookup.
//   idx    : raster index 0..63
//   chroma : 0 luma table, 1 chroma table
//   q      : quantizer step
//   r      : ceil(2^(IN_W+8) / q); every Q >= 10, so R fits in IN_W+6 bits
module quant_recip_lut
    import quant_pkg::*;
#(
    parameter int unsigned IN_W = 12
) (
    input  logic [5:0]      idx,
    input  logic            chroma,
    output logic [6:0]      q,
    output logic [IN_W+5:0] r
);
    localparam recip_tab_t LUMA_R   = recip_table(IN_W, 1'b0);
    localparam recip_tab_t CHROMA_R = recip_table(IN_W, 1'b1);

    always_comb begin
        q = chroma ? CHROMA_Q[idx] : LUMA_Q[idx];
        r = chroma ? CHROMA_R[idx][IN_W+5:0] : LUMA_R[idx][IN_W+5:0];
    end
endmodule

// File: rtl/quant_stream.sv
// quant_stream: 3-stage streaming JPEG quantizer with valid/ready flow control.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : quant_stream_if.slave (coefficient in, quantized out, err_sync)
// Result is sign(x) * floor(|x| / Q), saturated to OUT_W bits. Division is done
// as a multiply by R = ceil(2^S / Q) followed by a right shift by S = IN_W+8.
// Define QUANT_ROUND_EN to round half away from zero instead of truncating.
module quant_stream
    import quant_pkg::*;
#(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned OUT_W = 12
) (
    input logic          clk,
    input logic          rst_n,
    quant_stream_if.slave bus
);
    localparam int unsigned S  = IN_W + 8;
    localparam int unsigned RW = IN_W + 6;
    localparam int unsigned MW = IN_W + 1;   // |x| = 2^(IN_W-1) needs one extra bit
    localparam int unsigned PW = MW + RW;
    localparam logic [63:0]      POS_MAX = (64'd1 << (OUT_W - 1)) - 64'd1;
    localparam logic [OUT_W-1:0] POS_SAT = POS_MAX[OUT_W-1:0];
    localparam logic [OUT_W-1:0] NEG_SAT = {1'b1, {(OUT_W - 1){1'b0}}};

    logic en, accept;
    logic [5:0] idx_q, cur_idx;
    logic tbl_q, cur_tbl, err_q;
    logic [6:0] lut_q;
    logic [RW-1:0] lut_r;
    logic sign_in;
    logic [MW-1:0] x_ext, mag, mag_n;

    side_t s0_q, s1_q;
    logic [MW-1:0] mag0_q;
    logic [RW-1:0] r0_q;
    logic [PW-1:0] prod1_q;
    logic [PW-S-1:0] quot;
    logic [63:0] qx;
    logic [OUT_W-1:0] qlo, sat;

    logic out_valid_q, out_sof_q, out_eob_q;
    logic [OUT_W-1:0] out_coeff_q;

    assign en     = !out_valid_q || bus.out_ready;
    assign accept = bus.in_valid && en;

    // A beat flagged sof is index 0 regardless of where the counter is.
    always_comb begin
        cur_idx = bus.in_sof ? 6'd0 : idx_q;
        cur_tbl = (cur_idx == 6'd0) ? bus.in_chroma : tbl_q;
    end

    quant_recip_lut #(.IN_W(IN_W)) u_lut (
        .idx    (cur_idx),
        .chroma (cur_tbl),
        .q      (lut_q),
        .r      (lut_r)
    );

    always_comb begin
        sign_in = bus.in_coeff[IN_W-1];
        x_ext   = {sign_in, bus.in_coeff};
        mag     = sign_in ? (~x_ext + MW'(1)) : x_ext;
`ifdef QUANT_ROUND_EN
        mag_n   = mag + MW'(lut_q[6:1]);
`else
        mag_n   = mag;
`endif
    end

`ifndef QUANT_ROUND_EN
    logic unused_q;
    assign unused_q = ^lut_q;
`endif

    logic unused_prod;
    assign unused_prod = ^prod1_q[S-1:0];

    always_comb begin
        quot = prod1_q[PW-1:S];
        qx   = 64'(quot);
        qlo  = qx[OUT_W-1:0];
        if (!s1_q.sign) begin
            sat = (qx > POS_MAX) ? POS_SAT : qlo;
        end else begin
            sat = (qx > POS_MAX + 64'd1) ? NEG_SAT : (~qlo + OUT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            tbl_q       <= 1'b0;
            err_q       <= 1'b0;
            s0_q        <= '0;
            s1_q        <= '0;
            mag0_q      <= '0;
            r0_q        <= '0;
            prod1_q     <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eob_q   <= 1'b0;
            out_coeff_q <= '0;
        end else begin
            // Counter follows acceptance, so output backpressure cannot skew it.
            err_q <= accept && bus.in_sof && (idx_q != 6'd0);
            if (accept) begin
                idx_q <= (cur_idx == 6'd63) ? 6'd0 : cur_idx + 6'd1;
                if (cur_idx == 6'd0) begin
                    tbl_q <= bus.in_chroma;
                end
            end
            if (en) begin
                s0_q.valid  <= bus.in_valid;
                s0_q.sign   <= sign_in;
                s0_q.sof    <= (cur_idx == 6'd0);
                s0_q.eob    <= (cur_idx == 6'd63);
                mag0_q      <= mag_n;
                r0_q        <= lut_r;
                s1_q        <= s0_q;
                prod1_q     <= PW'(mag0_q) * PW'(r0_q);
                out_valid_q <= s1_q.valid;
                out_sof_q   <= s1_q.valid && s1_q.sof;
                out_eob_q   <= s1_q.valid && s1_q.eob;
                out_coeff_q <= s1_q.valid ? sat : '0;
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eob   = out_eob_q;
    assign bus.out_coeff = out_coeff_q;
    assign bus.err_sync  = err_q;
endmodule
